// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and freeze controller for the 5-stage RISC-V pipeline.
// Detects memory waits, taken branches and load-use hazards, and drives the
// PC / pipeline-register enables, flushes and bubbles combinationally.
// It also keeps saturating event counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_if_id_Rs1,
    input  logic [4:0]       i_if_id_Rs2,
    input  logic             i_if_id_use_rs1,
    input  logic             i_if_id_use_rs2,
    input  logic             i_id_ex_MemRead,
    input  logic [4:0]       i_id_ex_Rd,
    input  logic             i_ex_branch_taken,
    input  logic             i_ex_mem_MemRead,
    input  logic             i_ex_mem_MemWrite,
    input  logic             i_dmem_ready,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_write,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_write,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_wait_cnt,
    output logic             o_mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [15:0]      TO_MAX  = 16'hFFFF;
    localparam logic [15:0]      TO_LIM  = 16'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic mem_wait;
    logic load_use;
    logic ev_branch;
    logic ev_stall;

    // Raw hazard conditions and their priority resolution (mem_wait > branch > load_use).
    always_comb begin
        mem_wait  = (i_ex_mem_MemRead | i_ex_mem_MemWrite) & ~i_dmem_ready;
        load_use  = i_id_ex_MemRead & (i_id_ex_Rd != 5'd0) &
                    ((i_if_id_use_rs1 & (i_id_ex_Rd == i_if_id_Rs1)) |
                     (i_if_id_use_rs2 & (i_id_ex_Rd == i_if_id_Rs2)));
        ev_branch = ~mem_wait & i_ex_branch_taken;
        ev_stall  = ~mem_wait & ~i_ex_branch_taken & load_use;
    end

    // Same-cycle pipeline controls; held at run values while reset is asserted.
    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_write  = 1'b1;
        o_id_ex_bubble = 1'b0;
        o_ex_mem_write = 1'b1;
        if (!i_reset) begin
            if (mem_wait) begin
                o_pc_write     = 1'b0;
                o_if_id_write  = 1'b0;
                o_id_ex_write  = 1'b0;
                o_ex_mem_write = 1'b0;
            end else if (ev_branch) begin
                o_if_id_flush  = 1'b1;
                o_id_ex_bubble = 1'b1;
            end else if (ev_stall) begin
                o_pc_write     = 1'b0;
                o_if_id_write  = 1'b0;
                o_id_ex_bubble = 1'b1;
            end
        end
    end

    // Next event state, saturating counters and the sticky timeout flag.
    always_comb begin
        state_d       = ST_RUN;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        to_cnt_d      = 16'd0;
        mem_timeout_d = mem_timeout_q;
        if (mem_wait) begin
            state_d       = ST_MEM_WAIT;
            wait_cnt_d    = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
            to_cnt_d      = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 16'd1;
            mem_timeout_d = mem_timeout_q | (to_cnt_d >= TO_LIM);
        end else if (ev_branch) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
        end else if (ev_stall) begin
            state_d     = ST_STALL;
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
    end

    // State and monitoring registers with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            to_cnt_q      <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign o_state       = state_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;
    assign o_wait_cnt    = wait_cnt_q;
    assign o_mem_timeout = mem_timeout_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and freeze controller for the 5-stage RISC-V pipeline. It consumes the IF/ID, ID/EX and EX/MEM register outputs plus the data-memory ready handshake. From these it drives the write-enable, flush and bubble controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers. It also keeps saturating event counters and a sticky memory-timeout flag for debug and performance monitoring.

## Interface
- CNT_W, 32, width of each event counter
- MEM_TIMEOUT, 255, consecutive memory-wait cycles after which the timeout flag sets (1..2^16-1)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_if_id_Rs1  in  5  rs1 field of the instruction in ID
- i_if_id_Rs2  in  5  rs2 field of the instruction in ID
- i_if_id_use_rs1  in  1  the ID instruction reads rs1
- i_if_id_use_rs2  in  1  the ID instruction reads rs2
- i_id_ex_MemRead  in  1  the EX-stage instruction is a load
- i_id_ex_Rd  in  5  destination of the EX-stage instruction
- i_ex_branch_taken  in  1  branch/jump resolved taken in EX
- i_ex_mem_MemRead  in  1  the MEM-stage instruction reads dmem
- i_ex_mem_MemWrite  in  1  the MEM-stage instruction writes dmem
- i_dmem_ready  in  1  dmem completes the MEM-stage access this cycle
- o_pc_write  out  1  PC update enable
- o_if_id_write  out  1  IF/ID load enable
- o_if_id_flush  out  1  IF/ID loads a NOP
- o_id_ex_write  out  1  ID/EX load enable
- o_id_ex_bubble  out  1  ID/EX loads all control signals as 0
- o_ex_mem_write  out  1  EX/MEM and MEM/WB load enable
- o_state  out  2  registered event state: 0 RUN, 1 STALL, 2 FLUSH, 3 MEM_WAIT
- o_stall_cnt  out  CNT_W  load-use stall cycles
- o_flush_cnt  out  CNT_W  taken-branch flushes
- o_wait_cnt  out  CNT_W  memory-wait cycles
- o_mem_timeout  out  1  sticky: one memory wait reached MEM_TIMEOUT cycles

## Operation
- The block evaluates these conditions combinationally each cycle:
  - mem_wait = (i_ex_mem_MemRead | i_ex_mem_MemWrite) & ~i_dmem_ready.
  - load_use = i_id_ex_MemRead & (i_id_ex_Rd != 0) & ((i_if_id_use_rs1 & i_id_ex_Rd == i_if_id_Rs1) | (i_if_id_use_rs2 & i_id_ex_Rd == i_if_id_Rs2)).
- Priority is mem_wait > branch > load_use > run. The event is the highest-priority true condition.
- Control outputs are Mealy and react in the same cycle:
  - mem_wait: all four write enables 0; flush 0; bubble 0. The whole pipeline freezes, including any pending branch, which is re-evaluated when the freeze releases.
  - branch (i_ex_branch_taken, no mem_wait): o_pc_write=1; o_if_id_write=1, o_if_id_flush=1; o_id_ex_write=1, o_id_ex_bubble=1; o_ex_mem_write=1. A simultaneous load_use is ignored because its instruction is being flushed.
  - load_use only: o_pc_write=0; o_if_id_write=0; o_id_ex_write=1, o_id_ex_bubble=1; o_ex_mem_write=1; flush 0.
  - run: all write enables 1; flush 0; bubble 0.
- FSM state register: next state = STALL, FLUSH, MEM_WAIT or RUN according to the current event. o_state is that register.
- Counters:
  - o_stall_cnt increments once per load_use-event cycle.
  - o_flush_cnt increments once per branch-event cycle.
  - o_wait_cnt increments once per mem_wait cycle.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Timeout counter (internal, 16 bit):
  - Increments in each mem_wait cycle.
  - Clears in any cycle without mem_wait.
  - When it reaches MEM_TIMEOUT, o_mem_timeout sets on the next edge and stays set until reset.
  - It saturates rather than wraps.

## Timing
- Reset values (asynchronous, while i_reset is high):
  - o_state=RUN.
  - All counters 0; timeout counter 0; o_mem_timeout=0.
  - Control outputs forced to run values: write enables 1, flush 0, bubble 0.
- Control-output latency is 0 cycles, combinational from inputs. o_state, counters and o_mem_timeout lag the event by 1 clock.
- A load-use hazard produces exactly one bubble cycle. The next cycle ID/EX holds the bubble (MemRead=0), so load_use is false and the stall does not repeat.
- A memory wait of N cycles gives N freeze cycles. On the first cycle with i_dmem_ready=1 the pipeline advances.
- Reset asserted mid-stall or mid-wait returns the block to RUN immediately. Counters clear.

## Test plan
- Load-use: i_id_ex_MemRead=1, Rd=5, Rs1=5, use_rs1=1 for 1 cycle -> that cycle o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1; next edge o_state=1, o_stall_cnt=1.
- Rd=0 or use flags 0 with matching registers -> no stall; o_state stays 0.
- Branch taken together with a load_use match -> flush=1, bubble=1, o_pc_write=1; o_flush_cnt=1, o_stall_cnt=0.
- MemRead in MEM with i_dmem_ready=0 for 3 cycles, and i_ex_branch_taken=1 throughout -> 3 cycles with all write enables 0 and no flush; o_wait_cnt=3; the 4th cycle (ready=1) flushes and o_flush_cnt=1.
- MEM_TIMEOUT=4, memory wait held 4 cycles -> o_mem_timeout=1 after the 4th wait edge, and it stays 1 after ready returns until i_reset.
- CNT_W=4, 20 load_use cycles -> o_stall_cnt saturates at 15. Then pulse i_reset mid-wait -> counters 0, o_state=0 asynchronously.
